// File: rtl/uart_loader.sv
// Host-side serial monitor: decodes UART commands to load, dump and start programs
// in the shared 512x8 program RAM, and owns the UART/RAM ports while the CPU is idle.
module uart_loader #(
  parameter logic [23:0] TIMEOUT = 24'd1_200_000,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       received,
  output logic [7:0] tx_byte,
  output logic       transmit,
  input  logic       is_transmitting,
  output logic [8:0] raddr,
  input  logic [7:0] dread,
  output logic [8:0] waddr,
  output logic [7:0] dwrite,
  output logic       write_en,
  output logic [8:0] startaddr,
  output logic       cpu_run,
  input  logic       halted,
  output logic       cpu_active,
  output logic       busy
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;

  typedef enum logic [3:0] {
    IDLE, ADDRH, ADDRL, LEN, WDATA, RSET, RWAIT, RSAMPLE, SEND, SENDGAP, RUN
  } state_t;

  state_t      state, state_next;
  logic [7:0]  cmd;
  logic        addr_hi;
  logic [8:0]  addr;
  logic [8:0]  count;
  logic [23:0] idle_cnt;
  logic        counting;
  logic        timed_out;

  // Only states that expect another host byte run the inter-byte timer.
  assign counting  = (state == ADDRH) || (state == ADDRL) || (state == LEN) || (state == WDATA);
  assign timed_out = (idle_cnt == TIMEOUT - 24'd1) && !received;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (received) begin
        if (rx_byte == CMD_W || rx_byte == CMD_R || rx_byte == CMD_G) state_next = ADDRH;
        else                                                          state_next = SEND;
      end
      ADDRH: if (received) state_next = ADDRL;
             else if (timed_out) state_next = IDLE;
      ADDRL: if (received) state_next = (cmd == CMD_G) ? RUN : LEN;
             else if (timed_out) state_next = IDLE;
      LEN: if (received) state_next = (cmd == CMD_W) ? WDATA : RSET;
           else if (timed_out) state_next = IDLE;
      WDATA: if (received) state_next = (count == 9'd1) ? SEND : WDATA;
             else if (timed_out) state_next = IDLE;
      RSET:    state_next = RWAIT;
      RWAIT:   state_next = RSAMPLE;
      RSAMPLE: state_next = SEND;
      SEND:    if (!is_transmitting) state_next = SENDGAP;
      // The gap cycle lets the transmitter's busy flag catch up before the next send.
      SENDGAP: state_next = (cmd == CMD_R && count != 9'd0) ? RSET : IDLE;
      RUN:     if (halted) state_next = SEND;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    transmit = (state == SEND) && !is_transmitting;
    busy     = (state != IDLE);
    raddr    = addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= 8'd0;
      addr_hi    <= 1'b0;
      addr       <= 9'd0;
      count      <= 9'd0;
      idle_cnt   <= 24'd0;
      tx_byte    <= 8'd0;
      waddr      <= 9'd0;
      dwrite     <= 8'd0;
      write_en   <= 1'b0;
      startaddr  <= 9'd0;
      cpu_run    <= 1'b0;
      cpu_active <= 1'b0;
    end else begin
      write_en <= 1'b0;
      cpu_run  <= 1'b0;
      if (!counting || received) idle_cnt <= 24'd0;
      else                       idle_cnt <= idle_cnt + 24'd1;

      case (state)
        IDLE: if (received) begin
          cmd <= rx_byte;
          if (rx_byte != CMD_W && rx_byte != CMD_R && rx_byte != CMD_G) tx_byte <= NAK;
        end
        ADDRH: if (received) addr_hi <= rx_byte[0];
        ADDRL: if (received) begin
          addr <= {addr_hi, rx_byte};
          if (cmd == CMD_G) begin
            startaddr  <= {addr_hi, rx_byte};
            cpu_run    <= 1'b1;
            cpu_active <= 1'b1;
          end
        end
        LEN: if (received) count <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
        WDATA: if (received) begin
          waddr    <= addr;
          dwrite   <= rx_byte;
          write_en <= 1'b1;
          addr     <= addr + 9'd1;
          count    <= count - 9'd1;
          if (count == 9'd1) tx_byte <= ACK;
        end
        RSAMPLE: begin
          tx_byte <= dread;
          addr    <= addr + 9'd1;
          count   <= count - 9'd1;
        end
        RUN: if (halted) begin
          cpu_active <= 1'b0;
          tx_byte    <= ACK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader with a registered-read RAM model
// and a simple UART transmitter model that stays busy for a fixed number of cycles.
module tb_uart_loader;
  localparam logic [23:0] TO = 24'd200;
  localparam int TX_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       received;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       is_transmitting;
  logic [8:0] raddr;
  logic [7:0] dread;
  logic [8:0] waddr;
  logic [7:0] dwrite;
  logic       write_en;
  logic [8:0] startaddr;
  logic       cpu_run;
  logic       halted;
  logic       cpu_active;
  logic       busy;

  int checks = 0;
  int failures = 0;

  uart_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
    .raddr(raddr), .dread(dread), .waddr(waddr), .dwrite(dwrite),
    .write_en(write_en), .startaddr(startaddr), .cpu_run(cpu_run),
    .halted(halted), .cpu_active(cpu_active), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy flag rises the cycle after a transmit pulse.
  int   tx_cnt = 0;
  logic force_busy = 1'b0;
  assign is_transmitting = (tx_cnt != 0) || force_busy;
  always @(posedge clk) begin
    if (transmit) tx_cnt <= TX_CYCLES;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  logic [7:0] ram [512];
  logic       fill_en = 1'b0;
  logic [8:0] fill_addr = 9'd0;
  logic [7:0] fill_data = 8'd0;
  always @(posedge clk) begin
    if (fill_en) ram[fill_addr] <= fill_data;
    else if (write_en) ram[waddr] <= dwrite;
    dread <= ram[raddr];
  end

  logic [7:0] exp_mem [512];
  logic [8:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] tx_q[$];
  int run_count = 0;
  int busy_violations = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (write_en) begin
        wr_addr_q.push_back(waddr);
        wr_data_q.push_back(dwrite);
      end
      if (transmit) begin
        tx_q.push_back(tx_byte);
        if (is_transmitting) busy_violations++;
      end
      if (cpu_run) run_count++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al, input logic [7:0] len);
    send_byte(c);
    send_byte(ah);
    send_byte(al);
    send_byte(len);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((busy || is_transmitting) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(busy || is_transmitting), 32'd0);
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic check_tx(input string tag, input int idx, input logic [7:0] exp);
    check_output(tag, (idx < tx_q.size()) ? 32'(tx_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [8:0] a, input logic [7:0] d);
    check_output(tag, (idx < wr_addr_q.size()) ? 32'({wr_addr_q[idx], wr_data_q[idx]}) : 32'hFFFF_FFFF,
                 32'({a, d}));
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    logic [8:0] a;
    rst = 1'b1;
    rx_byte = 8'd0;
    received = 1'b0;
    halted = 1'b0;

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      fill_en   = 1'b1;
      fill_addr = 9'(i);
      fill_data = 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    @(negedge clk);
    fill_en = 1'b0;
    wait_cycles(2);

    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_pulses", 32'({transmit, write_en, cpu_run, cpu_active}), 32'd0);
    check_output("reset_data", 32'({tx_byte, dwrite}), 32'd0);
    check_output("reset_addrs", 32'({raddr, waddr, startaddr}), 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    $display("[TB] write three bytes at 0x010");
    clear_obs();
    apply_stimulus(8'h57, 8'h00, 8'h10, 8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    exp_mem[9'h010] = 8'hAA; exp_mem[9'h011] = 8'hBB; exp_mem[9'h012] = 8'hCC;
    wait_idle("w1_done", 200);
    check_output("w1_count", 32'(wr_addr_q.size()), 32'd3);
    check_wr("w1_wr0", 0, 9'h010, 8'hAA);
    check_wr("w1_wr1", 1, 9'h011, 8'hBB);
    check_wr("w1_wr2", 2, 9'h012, 8'hCC);
    check_output("w1_txcount", 32'(tx_q.size()), 32'd1);
    check_tx("w1_ack", 0, 8'h06);

    $display("[TB] read back three bytes");
    clear_obs();
    apply_stimulus(8'h52, 8'h00, 8'h10, 8'h03);
    wait_idle("r1_done", 300);
    check_output("r1_txcount", 32'(tx_q.size()), 32'd3);
    check_tx("r1_b0", 0, 8'hAA);
    check_tx("r1_b1", 1, 8'hBB);
    check_tx("r1_b2", 2, 8'hCC);

    $display("[TB] write across the 0x1FF wrap");
    clear_obs();
    apply_stimulus(8'h57, 8'h01, 8'hFE, 8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_mem[9'h1FE] = 8'h11; exp_mem[9'h1FF] = 8'h22; exp_mem[9'h000] = 8'h33; exp_mem[9'h001] = 8'h44;
    wait_idle("w2_done", 200);
    check_wr("w2_wr0", 0, 9'h1FE, 8'h11);
    check_wr("w2_wr1", 1, 9'h1FF, 8'h22);
    check_wr("w2_wr2", 2, 9'h000, 8'h33);
    check_wr("w2_wr3", 3, 9'h001, 8'h44);
    check_tx("w2_ack", 0, 8'h06);

    $display("[TB] 256-byte read with AH upper bits set");
    clear_obs();
    apply_stimulus(8'h52, 8'hFF, 8'hFE, 8'h00);
    wait_idle("r256_done", 8000);
    check_output("r256_txcount", 32'(tx_q.size()), 32'd256);
    check_tx("r256_first", 0, 8'h11);
    check_tx("r256_wrapped", 2, 8'h33);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = 9'h1FE + 9'(i);
      if (i >= tx_q.size() || tx_q[i] !== exp_mem[a]) bad++;
    end
    check_output("r256_data", 32'(bad), 32'd0);

    $display("[TB] go command");
    clear_obs();
    run_count = 0;
    send_byte(8'h47); send_byte(8'h00); send_byte(8'h20);
    check_output("g_run_pulses", 32'(run_count), 32'd1);
    check_output("g_startaddr", 32'(startaddr), 32'h020);
    check_output("g_active", 32'(cpu_active), 32'd1);
    send_byte(8'h52); send_byte(8'h41); send_byte(8'h57);
    wait_cycles(20);
    check_output("g_ignored_tx", 32'(tx_q.size()), 32'd0);
    check_output("g_ignored_wr", 32'(wr_addr_q.size()), 32'd0);
    check_output("g_busy", 32'(busy), 32'd1);
    wait_cycles(70);
    @(negedge clk); halted = 1'b1;
    @(negedge clk); halted = 1'b0;
    check_output("g_active_fall", 32'(cpu_active), 32'd0);
    wait_idle("g_done", 100);
    check_output("g_txcount", 32'(tx_q.size()), 32'd1);
    check_tx("g_ack", 0, 8'h06);
    check_output("g_run_total", 32'(run_count), 32'd1);

    clear_obs();
    @(negedge clk); halted = 1'b1;
    @(negedge clk); halted = 1'b0;
    wait_cycles(20);
    check_output("halt_idle_ignored", 32'({busy, 8'(tx_q.size())}), 32'd0);

    $display("[TB] read with transmitter held busy");
    clear_obs();
    force_busy = 1'b1;
    apply_stimulus(8'h52, 8'h00, 8'h10, 8'h03);
    wait_cycles(500);
    check_output("hold_no_tx", 32'(tx_q.size()), 32'd0);
    check_output("hold_busy", 32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_idle("hold_done", 300);
    check_output("hold_txcount", 32'(tx_q.size()), 32'd3);
    check_tx("hold_b0", 0, 8'hAA);
    check_tx("hold_b1", 1, 8'hBB);
    check_tx("hold_b2", 2, 8'hCC);
    check_output("tx_while_busy", 32'(busy_violations), 32'd0);

    $display("[TB] unknown command");
    clear_obs();
    send_byte(8'h41);
    wait_idle("nak_done", 100);
    check_output("nak_txcount", 32'(tx_q.size()), 32'd1);
    check_tx("nak_byte", 0, 8'h15);

    $display("[TB] timeout mid-command");
    clear_obs();
    send_byte(8'h57); send_byte(8'h00);
    wait_cycles(int'(TO) - 20);
    check_output("to_still_busy", 32'(busy), 32'd1);
    wait_cycles(40);
    check_output("to_idle", 32'(busy), 32'd0);
    check_output("to_silent", 32'(tx_q.size() + wr_addr_q.size()), 32'd0);
    apply_stimulus(8'h57, 8'h00, 8'h30, 8'h01);
    send_byte(8'h77);
    exp_mem[9'h030] = 8'h77;
    wait_idle("to_next_done", 200);
    check_wr("to_next_wr", 0, 9'h030, 8'h77);
    check_tx("to_next_ack", 0, 8'h06);

    $display("[TB] reset in the middle of a write");
    clear_obs();
    apply_stimulus(8'h57, 8'h00, 8'h40, 8'h04);
    send_byte(8'hD1); send_byte(8'hD2);
    exp_mem[9'h040] = 8'hD1; exp_mem[9'h041] = 8'hD2;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_pulses", 32'({transmit, write_en, cpu_run, cpu_active}), 32'd0);
    check_output("mid_rst_data", 32'({tx_byte, dwrite, waddr}), 32'd0);
    rst = 1'b0;
    wait_cycles(30);
    check_output("mid_rst_no_ack", 32'(tx_q.size()), 32'd0);
    check_output("mid_rst_writes", 32'(wr_addr_q.size()), 32'd2);
    clear_obs();
    apply_stimulus(8'h52, 8'h00, 8'h40, 8'h02);
    wait_idle("mid_rst_read_done", 300);
    check_tx("mid_rst_kept0", 0, exp_mem[9'h040]);
    check_tx("mid_rst_kept1", 1, exp_mem[9'h041]);

    $display("[TB] reset while CPU running");
    clear_obs();
    send_byte(8'h47); send_byte(8'h00); send_byte(8'h00);
    check_output("run_rst_active_before", 32'(cpu_active), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_output("run_rst_active_after", 32'({cpu_active, busy}), 32'd0);
    rst = 1'b0;
    wait_cycles(30);
    check_output("run_rst_no_ack", 32'(tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
